// File: rtl/id_pkg.sv
// Shared decode constants for the ID/EX forwarding stage: opcodes, ALU codes,
// the registered control bundle and its bubble value.
package id_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;

    localparam logic [5:0] FN_SLT     = 6'b101010;
    localparam logic [5:0] FN_SLTU    = 6'b101011;

    typedef enum logic [7:0] {
        ALU_NOP   = 8'h00,
        ALU_SLT   = 8'h2A,
        ALU_SLTU  = 8'h2B,
        ALU_ADDIU = 8'h56,
        ALU_AND   = 8'h24,
        ALU_OR    = 8'h25,
        ALU_XOR   = 8'h26,
        ALU_LUI   = 8'h5C
    } aluop_e;

    typedef enum logic [2:0] {
        SEL_NOP   = 3'd0,
        SEL_LOGIC = 3'd1,
        SEL_SHIFT = 3'd2,
        SEL_ARITH = 3'd4
    } alusel_e;

    typedef enum logic [1:0] {
        IMM_NONE,
        IMM_SEXT,
        IMM_ZEXT,
        IMM_LUI
    } immsel_e;

    typedef struct packed {
        aluop_e  aluop;
        alusel_e alusel;
        logic    wreg;
        logic    valid;
        logic    inval;
    } idex_ctl_t;

    localparam idex_ctl_t BUBBLE_CTL = '{
        aluop:  ALU_NOP,
        alusel: SEL_NOP,
        wreg:   1'b0,
        valid:  1'b0,
        inval:  1'b0
    };

    // Extended to 64 bits; callers truncate to their datapath width.
    function automatic logic [63:0] ext_imm(input immsel_e sel, input logic [15:0] imm);
        logic [63:0] v;
        v = '0;
        case (sel)
            IMM_SEXT: v = 64'($signed(imm));
            IMM_ZEXT: v = 64'(imm);
            IMM_LUI:  v = 64'($signed({imm, 16'h0000}));
            default:  v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Operand select for one read port: immediate, hard-wired zero, the lowest
// matching forwarding slot, or regfile data.
module id_fwd_mux #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned N_FWD  = 2
) (
    input  logic                      i_read,
    input  logic [REG_AW-1:0]         i_addr,
    input  logic [DATA_W-1:0]         i_imm,
    input  logic [DATA_W-1:0]         i_rf_data,
    input  logic [N_FWD-1:0]          i_fwd_wreg,
    input  logic [N_FWD*REG_AW-1:0]   i_fwd_wd,
    input  logic [N_FWD*DATA_W-1:0]   i_fwd_wdata,
    output logic [DATA_W-1:0]         o_data
);

    logic w_hit;

    always_comb begin
        o_data = i_rf_data;
        w_hit  = 1'b0;
        if (!i_read) begin
            o_data = i_imm;
        end else if (i_addr == '0) begin
            o_data = '0;
        end else begin
            // Ascending scan with a hit flag keeps slot 0 (youngest) dominant.
            for (int unsigned k = 0; k < N_FWD; k++) begin
                if (!w_hit && i_fwd_wreg[k] && (i_fwd_wd[k*REG_AW +: REG_AW] == i_addr)) begin
                    o_data = i_fwd_wdata[k*DATA_W +: DATA_W];
                    w_hit  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/id_fwd_stage.sv
// Instruction decode for the compare/logic/immediate group with operand
// forwarding, load-use detection and the registered ID/EX boundary.
module id_fwd_stage
    import id_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned N_FWD  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               pc_i,
    input  logic [31:0]               inst_i,
    input  logic                      valid_i,
    input  logic [DATA_W-1:0]         reg1_data_i,
    input  logic [DATA_W-1:0]         reg2_data_i,
    output logic                      reg1_read_o,
    output logic                      reg2_read_o,
    output logic [REG_AW-1:0]         reg1_addr_o,
    output logic [REG_AW-1:0]         reg2_addr_o,
    input  logic [N_FWD-1:0]          fwd_wreg_i,
    input  logic [N_FWD*REG_AW-1:0]   fwd_wd_i,
    input  logic [N_FWD*DATA_W-1:0]   fwd_wdata_i,
    input  logic                      ex_load_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    output logic                      stallreq_o,
    output logic [7:0]                aluop_o,
    output logic [2:0]                alusel_o,
    output logic [DATA_W-1:0]         reg1_o,
    output logic [DATA_W-1:0]         reg2_o,
    output logic [REG_AW-1:0]         wd_o,
    output logic                      wreg_o,
    output logic                      valid_o,
    output logic                      inval_o
);

    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [REG_AW-1:0] w_rd;
    logic [15:0]       w_imm;

    logic              w_rd1;
    logic              w_rd2;
    logic              w_itype;
    immsel_e           w_imm1_sel;
    immsel_e           w_imm2_sel;
    idex_ctl_t         w_ctl;
    logic [REG_AW-1:0] w_wd;
    logic [DATA_W-1:0] w_imm1;
    logic [DATA_W-1:0] w_imm2;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;
    logic              w_hz1;
    logic              w_hz2;
    logic              w_unused_pc;

    idex_ctl_t         r_ctl;
    logic [REG_AW-1:0] r_wd;
    logic [DATA_W-1:0] r_reg1;
    logic [DATA_W-1:0] r_reg2;

    assign w_op        = inst_i[31:26];
    assign w_funct     = inst_i[5:0];
    assign w_rs        = REG_AW'(inst_i[25:21]);
    assign w_rt        = REG_AW'(inst_i[20:16]);
    assign w_rd        = REG_AW'(inst_i[15:11]);
    assign w_imm       = inst_i[15:0];
    assign w_unused_pc = ^pc_i;

    always_comb begin
        w_rd1      = 1'b0;
        w_rd2      = 1'b0;
        w_itype    = 1'b0;
        w_imm1_sel = IMM_NONE;
        w_imm2_sel = IMM_NONE;
        w_wd       = '0;
        w_ctl      = '{aluop: ALU_NOP, alusel: SEL_NOP, wreg: 1'b0, valid: 1'b1, inval: 1'b0};
        case (w_op)
            OP_SPECIAL: begin
                if (w_funct == FN_SLT || w_funct == FN_SLTU) begin
                    w_rd1        = 1'b1;
                    w_rd2        = 1'b1;
                    w_wd         = w_rd;
                    w_ctl.wreg   = 1'b1;
                    w_ctl.alusel = SEL_ARITH;
                    w_ctl.aluop  = (w_funct == FN_SLT) ? ALU_SLT : ALU_SLTU;
                end else begin
                    w_ctl.inval  = 1'b1;
                end
            end
            OP_ADDIU: begin
                w_itype = 1'b1; w_rd1 = 1'b1; w_imm2_sel = IMM_SEXT;
                w_ctl.aluop = ALU_ADDIU; w_ctl.alusel = SEL_ARITH;
            end
            OP_SLTI: begin
                w_itype = 1'b1; w_rd1 = 1'b1; w_imm2_sel = IMM_SEXT;
                w_ctl.aluop = ALU_SLT; w_ctl.alusel = SEL_ARITH;
            end
            OP_SLTIU: begin
                w_itype = 1'b1; w_rd1 = 1'b1; w_imm2_sel = IMM_SEXT;
                w_ctl.aluop = ALU_SLTU; w_ctl.alusel = SEL_ARITH;
            end
            OP_ANDI: begin
                w_itype = 1'b1; w_rd1 = 1'b1; w_imm2_sel = IMM_ZEXT;
                w_ctl.aluop = ALU_AND; w_ctl.alusel = SEL_LOGIC;
            end
            OP_ORI: begin
                w_itype = 1'b1; w_rd1 = 1'b1; w_imm2_sel = IMM_ZEXT;
                w_ctl.aluop = ALU_OR; w_ctl.alusel = SEL_LOGIC;
            end
            OP_XORI: begin
                w_itype = 1'b1; w_rd1 = 1'b1; w_imm2_sel = IMM_ZEXT;
                w_ctl.aluop = ALU_XOR; w_ctl.alusel = SEL_LOGIC;
            end
            OP_LUI: begin
                w_itype = 1'b1; w_imm1_sel = IMM_LUI;
                w_ctl.aluop = ALU_LUI; w_ctl.alusel = SEL_LOGIC;
            end
            default: begin
                w_ctl.inval = 1'b1;
            end
        endcase
        if (w_itype) begin
            w_wd       = w_rt;
            w_ctl.wreg = 1'b1;
        end
        if (w_wd == '0) begin
            w_ctl.wreg = 1'b0;
        end
    end

    assign w_imm1 = DATA_W'(ext_imm(w_imm1_sel, w_imm));
    assign w_imm2 = DATA_W'(ext_imm(w_imm2_sel, w_imm));

    assign reg1_read_o = rst & w_rd1;
    assign reg2_read_o = rst & w_rd2;
    assign reg1_addr_o = reg1_read_o ? w_rs : '0;
    assign reg2_addr_o = reg2_read_o ? w_rt : '0;

    id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .N_FWD(N_FWD)) u_mux1 (
        .i_read      (w_rd1),
        .i_addr      (w_rs),
        .i_imm       (w_imm1),
        .i_rf_data   (reg1_data_i),
        .i_fwd_wreg  (fwd_wreg_i),
        .i_fwd_wd    (fwd_wd_i),
        .i_fwd_wdata (fwd_wdata_i),
        .o_data      (w_op1)
    );

    id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .N_FWD(N_FWD)) u_mux2 (
        .i_read      (w_rd2),
        .i_addr      (w_rt),
        .i_imm       (w_imm2),
        .i_rf_data   (reg2_data_i),
        .i_fwd_wreg  (fwd_wreg_i),
        .i_fwd_wd    (fwd_wd_i),
        .i_fwd_wdata (fwd_wdata_i),
        .o_data      (w_op2)
    );

    assign w_hz1 = w_rd1 && (w_rs != '0) && (w_rs == fwd_wd_i[REG_AW-1:0]);
    assign w_hz2 = w_rd2 && (w_rt != '0) && (w_rt == fwd_wd_i[REG_AW-1:0]);
    assign stallreq_o = rst & valid_i & ex_load_i & fwd_wreg_i[0] & ~flush_i & (w_hz1 | w_hz2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctl  <= BUBBLE_CTL;
            r_wd   <= '0;
            r_reg1 <= '0;
            r_reg2 <= '0;
        end else if (flush_i || (!stall_i && (stallreq_o || !valid_i))) begin
            r_ctl  <= BUBBLE_CTL;
            r_wd   <= '0;
            r_reg1 <= '0;
            r_reg2 <= '0;
        end else if (!stall_i) begin
            r_ctl  <= w_ctl;
            r_wd   <= w_wd;
            r_reg1 <= w_op1;
            r_reg2 <= w_op2;
        end
    end

    assign aluop_o  = r_ctl.aluop;
    assign alusel_o = r_ctl.alusel;
    assign wreg_o   = r_ctl.wreg;
    assign valid_o  = r_ctl.valid;
    assign inval_o  = r_ctl.inval;
    assign wd_o     = r_wd;
    assign reg1_o   = r_reg1;
    assign reg2_o   = r_reg2;

endmodule
